// File: rtl/rom_arbiter_pkg.sv
// Shared constants and the last-grant encoding for the instruction ROM arbiter.
package rom_arbiter_pkg;

  localparam int unsigned INST_ADDR_BUS     = 32;
  localparam int unsigned INST_BUS          = 32;
  localparam int unsigned INST_MEM_NUM      = 131071;
  localparam int unsigned INST_MEM_NUM_LOG2 = 17;

  localparam logic CHIP_ENABLE  = 1'b1;
  localparam logic CHIP_DISABLE = 1'b0;
  localparam logic RST_ENABLE   = 1'b1;

  typedef enum logic {
    ARB_IF  = 1'b0,
    ARB_DBG = 1'b1
  } arb_port_e;

endpackage

// File: rtl/rom_arbiter_rr_arb2.sv
// Two-input round-robin grant; the port not granted last wins a contention.
module rom_arbiter_rr_arb2
  import rom_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req_if,
  input  logic req_dbg,
  output logic gnt_if,
  output logic gnt_dbg
);

  arb_port_e last_grant_q, last_grant_d;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
    gnt_if       = 1'b0;
    gnt_dbg      = 1'b0;
    last_grant_d = last_grant_q;
    if (rst != RST_ENABLE) begin
      if (req_if && req_dbg) begin
        gnt_if  = (last_grant_q == ARB_DBG);
        gnt_dbg = (last_grant_q == ARB_IF);
      end else begin
        gnt_if  = req_if;
        gnt_dbg = req_dbg;
      end
    end
    if (gnt_if)  last_grant_d = ARB_IF;
    if (gnt_dbg) last_grant_d = ARB_DBG;
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) last_grant_q <= ARB_DBG;
    else                   last_grant_q <= last_grant_d;
  end

endmodule

// File: rtl/rom_arbiter.sv
// Shares the combinational instruction ROM between the IF fetch port and the debug read port.
module rom_arbiter
  import rom_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W    = INST_ADDR_BUS,
  parameter int unsigned DATA_W    = INST_BUS,
  parameter int unsigned MEM_WORDS = INST_MEM_NUM,
  parameter int unsigned MEM_LOG2  = INST_MEM_NUM_LOG2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_stall,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_err,
  input  logic              dbg_req,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic              dbg_gnt,
  output logic              dbg_valid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_err,
  output logic              rom_ce,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_inst
);

  // Takes the word address (byte address without its two ignored low bits).
  function automatic logic out_of_range(input logic [ADDR_W-3:0] waddr);
    logic [MEM_LOG2-1:0] idx;
    idx = waddr[MEM_LOG2-1:0];
    return (|waddr[ADDR_W-3:MEM_LOG2]) || ({{(32-MEM_LOG2){1'b0}}, idx} >= MEM_WORDS);
  endfunction

  logic              if_oor, dbg_oor;
  logic              if_valid_q, if_valid_d, dbg_valid_q, dbg_valid_d;
  logic              if_err_q, if_err_d, dbg_err_q, dbg_err_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d, dbg_rdata_q, dbg_rdata_d;

  rom_arbiter_rr_arb2 u_rr_arb2 (
    .clk     (clk),
    .rst     (rst),
    .req_if  (if_req),
    .req_dbg (dbg_req),
    .gnt_if  (if_gnt),
    .gnt_dbg (dbg_gnt)
  );

  assign if_stall = if_req & ~if_gnt;
  assign if_oor   = out_of_range(if_addr[ADDR_W-1:2]);
  assign dbg_oor  = out_of_range(dbg_addr[ADDR_W-1:2]);

  // An out-of-range grant still owns the slot, but the ROM stays disabled.
  always_comb begin
    rom_ce   = CHIP_DISABLE;
    rom_addr = '0;
    if (if_gnt) begin
      rom_addr = if_addr;
      rom_ce   = if_oor ? CHIP_DISABLE : CHIP_ENABLE;
    end else if (dbg_gnt) begin
      rom_addr = dbg_addr;
      rom_ce   = dbg_oor ? CHIP_DISABLE : CHIP_ENABLE;
    end
  end

  always_comb begin
    if_valid_d  = if_gnt;
    if_err_d    = if_err_q;
    if_rdata_d  = if_rdata_q;
    dbg_valid_d = dbg_gnt;
    dbg_err_d   = dbg_err_q;
    dbg_rdata_d = dbg_rdata_q;
    if (if_gnt) begin
      if_err_d   = if_oor;
      if_rdata_d = if_oor ? '0 : rom_inst;
    end
    if (dbg_gnt) begin
      dbg_err_d   = dbg_oor;
      dbg_rdata_d = dbg_oor ? '0 : rom_inst;
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      if_valid_q  <= 1'b0;
      if_err_q    <= 1'b0;
      if_rdata_q  <= '0;
      dbg_valid_q <= 1'b0;
      dbg_err_q   <= 1'b0;
      dbg_rdata_q <= '0;
    end else begin
      if_valid_q  <= if_valid_d;
      if_err_q    <= if_err_d;
      if_rdata_q  <= if_rdata_d;
      dbg_valid_q <= dbg_valid_d;
      dbg_err_q   <= dbg_err_d;
      dbg_rdata_q <= dbg_rdata_d;
    end
  end

  assign if_valid  = if_valid_q;
  assign if_err    = if_err_q;
  assign if_rdata  = if_rdata_q;
  assign dbg_valid = dbg_valid_q;
  assign dbg_err   = dbg_err_q;
  assign dbg_rdata = dbg_rdata_q;

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed self-checking bench for rom_arbiter with a small combinational ROM model.
module tb_rom_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, dbg_req;
  logic [31:0] if_addr, dbg_addr;
  logic        if_gnt, if_stall, if_valid, if_err;
  logic        dbg_gnt, dbg_valid, dbg_err;
  logic [31:0] if_rdata, dbg_rdata;
  logic        rom_ce;
  logic [31:0] rom_addr, rom_inst;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [16:0] idx);
    if (idx == 17'd1) return 32'h3401_1100;
    return 32'hA500_0000 ^ {15'd0, idx};
  endfunction

  // Disabled ROM returns garbage so a missing zero-fill is visible.
  assign rom_inst = rom_ce ? rom_word(rom_addr[18:2]) : 32'hDEAD_BEEF;

  rom_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_stall  (if_stall),
    .if_valid  (if_valid),
    .if_rdata  (if_rdata),
    .if_err    (if_err),
    .dbg_req   (dbg_req),
    .dbg_addr  (dbg_addr),
    .dbg_gnt   (dbg_gnt),
    .dbg_valid (dbg_valid),
    .dbg_rdata (dbg_rdata),
    .dbg_err   (dbg_err),
    .rom_ce    (rom_ce),
    .rom_addr  (rom_addr),
    .rom_inst  (rom_inst)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge, then let inputs settle.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_cycle();
    rst = 1'b1; if_req = 1'b0; dbg_req = 1'b0;
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; if_req = 1'b0; dbg_req = 1'b0; if_addr = '0; dbg_addr = '0;
    #2;

    // Reset: request during rst must not be granted
    if_req = 1'b1; if_addr = 32'h4;
    #1;
    check("rst_if_gnt", {31'd0, if_gnt}, 32'd0);
    check("rst_rom_ce", {31'd0, rom_ce}, 32'd0);
    check("rst_rom_addr", rom_addr, 32'd0);
    cycle();
    rst = 1'b0; if_req = 1'b0;
    #1;
    check("rst_if_valid", {31'd0, if_valid}, 32'd0);
    check("rst_if_rdata", if_rdata, 32'd0);
    check("rst_if_err", {31'd0, if_err}, 32'd0);
    check("rst_dbg_valid", {31'd0, dbg_valid}, 32'd0);
    check("rst_dbg_rdata", dbg_rdata, 32'd0);

    // Single fetch
    if_req = 1'b1; if_addr = 32'h0000_0004;
    #1;
    check("single_if_gnt", {31'd0, if_gnt}, 32'd1);
    check("single_if_stall", {31'd0, if_stall}, 32'd0);
    check("single_rom_ce", {31'd0, rom_ce}, 32'd1);
    check("single_rom_addr", rom_addr, 32'h4);
    cycle();
    if_req = 1'b0;
    check("single_if_valid", {31'd0, if_valid}, 32'd1);
    check("single_if_rdata", if_rdata, 32'h3401_1100);
    check("single_dbg_valid", {31'd0, dbg_valid}, 32'd0);
    check("single_dbg_rdata", dbg_rdata, 32'd0);

    // Contention after reset: IF, DBG, IF, DBG
    reset_cycle();
    if_req = 1'b1; dbg_req = 1'b1; if_addr = 32'h0; dbg_addr = 32'h8;
    for (int i = 0; i < 4; i++) begin
      logic exp_if;
      exp_if = (i % 2 == 0);
      #1;
      check($sformatf("cont%0d_if_gnt", i), {31'd0, if_gnt}, {31'd0, exp_if});
      check($sformatf("cont%0d_dbg_gnt", i), {31'd0, dbg_gnt}, {31'd0, ~exp_if});
      check($sformatf("cont%0d_if_stall", i), {31'd0, if_stall}, {31'd0, ~exp_if});
      check($sformatf("cont%0d_rom_addr", i), rom_addr, exp_if ? 32'h0 : 32'h8);
      cycle();
      check($sformatf("cont%0d_if_valid", i), {31'd0, if_valid}, {31'd0, exp_if});
      check($sformatf("cont%0d_dbg_valid", i), {31'd0, dbg_valid}, {31'd0, ~exp_if});
      if (exp_if) check($sformatf("cont%0d_if_rdata", i), if_rdata, 32'hA500_0000);
      else        check($sformatf("cont%0d_dbg_rdata", i), dbg_rdata, 32'hA500_0002);
    end

    // Out of range on DBG, then a legal read clears the error
    if_req = 1'b0; dbg_req = 1'b1; dbg_addr = 32'h0008_0000;
    #1;
    check("oor_dbg_gnt", {31'd0, dbg_gnt}, 32'd1);
    check("oor_rom_ce", {31'd0, rom_ce}, 32'd0);
    cycle();
    check("oor_dbg_valid", {31'd0, dbg_valid}, 32'd1);
    check("oor_dbg_err", {31'd0, dbg_err}, 32'd1);
    check("oor_dbg_rdata", dbg_rdata, 32'd0);
    dbg_addr = 32'h0000_0010;
    cycle();
    dbg_req = 1'b0;
    check("legal_dbg_valid", {31'd0, dbg_valid}, 32'd1);
    check("legal_dbg_err", {31'd0, dbg_err}, 32'd0);
    check("legal_dbg_rdata", dbg_rdata, 32'hA500_0004);

    // Top word index is out of range too
    dbg_req = 1'b1; dbg_addr = 32'h0007_FFFC;
    #1;
    check("topidx_rom_ce", {31'd0, rom_ce}, 32'd0);
    cycle();
    dbg_req = 1'b0;
    check("topidx_dbg_err", {31'd0, dbg_err}, 32'd1);

    // Idle and hold
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("idle%0d_rom_ce", i), {31'd0, rom_ce}, 32'd0);
      check($sformatf("idle%0d_rom_addr", i), rom_addr, 32'd0);
      cycle();
      check($sformatf("idle%0d_if_valid", i), {31'd0, if_valid}, 32'd0);
      check($sformatf("idle%0d_dbg_valid", i), {31'd0, dbg_valid}, 32'd0);
      check($sformatf("idle%0d_if_rdata", i), if_rdata, 32'hA500_0000);
    end

    // Misaligned address reads word1 without error
    if_req = 1'b1; if_addr = 32'h0000_0006;
    cycle();
    if_req = 1'b0;
    check("mis_if_valid", {31'd0, if_valid}, 32'd1);
    check("mis_if_rdata", if_rdata, 32'h3401_1100);
    check("mis_if_err", {31'd0, if_err}, 32'd0);

    // DBG wins next so last_grant is DBG-side before the reset test starts from IF
    dbg_req = 1'b1; dbg_addr = 32'h8;
    cycle();
    dbg_req = 1'b0;

    // Reset mid-operation: grant discarded, IF wins next contention
    rst = 1'b1; if_req = 1'b1; if_addr = 32'h4;
    #1;
    check("midrst_if_gnt", {31'd0, if_gnt}, 32'd0);
    cycle();
    rst = 1'b0; dbg_req = 1'b1; if_addr = 32'h0; dbg_addr = 32'h8;
    check("midrst_if_valid", {31'd0, if_valid}, 32'd0);
    check("midrst_if_rdata", if_rdata, 32'd0);
    #1;
    check("midrst_first_if_gnt", {31'd0, if_gnt}, 32'd1);
    check("midrst_first_dbg_gnt", {31'd0, dbg_gnt}, 32'd0);
    cycle();
    if_req = 1'b0; dbg_req = 1'b0;
    check("midrst_if_valid2", {31'd0, if_valid}, 32'd1);
    check("midrst_if_rdata2", if_rdata, 32'hA500_0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
